// File: rtl/shot_scoreboard.sv
// Shot gate and game scoreboard: launches shots, scores results with streak bonus, tracks the high score.
// shoot_out follows an accepted shoot_req by one cycle; new requests are dropped while a shot is in flight.
module shot_scoreboard #(
    parameter int SHOTS_PER_GAME  = 8,
    parameter int SCORE_W         = 6,
    parameter int STREAK_BONUS_AT = 3,
    parameter int TIMEOUT_CYC     = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ena,
    input  logic               start_new_game,
    input  logic               shoot_req,
    input  logic               result_valid,
    input  logic               hit,
    output logic               shoot_out,
    output logic               busy,
    output logic [3:0]         shots_left,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic [2:0]         streak,
    output logic               timeout_flag,
    output logic               game_over
);
    localparam int                 TMO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [3:0]         SHOTS_INIT = 4'(SHOTS_PER_GAME);
    localparam logic [3:0]         BONUS_AT   = 4'(STREAK_BONUS_AT);
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [TMO_W-1:0]   TMO_ONE    = TMO_W'(1);
    localparam logic [SCORE_W:0]   PTS_ONE    = (SCORE_W + 1)'(1);
    localparam logic [SCORE_W:0]   PTS_TWO    = (SCORE_W + 1)'(2);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_READY     = 2'd1,
        S_IN_FLIGHT = 2'd2,
        S_GAME_OVER = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_shots_left, w_shots_left_nxt;
    logic [SCORE_W-1:0] r_score, w_score_nxt;
    logic [SCORE_W-1:0] r_high_score, w_high_score_nxt;
    logic [2:0]         r_streak, w_streak_nxt;
    logic               r_timeout_flag, w_timeout_flag_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;
    logic               r_shoot_out;
    logic               w_launch;
    logic               w_resolve;

    logic [2:0]         w_streak_inc;
    logic [SCORE_W:0]   w_score_sum;
    logic [SCORE_W-1:0] w_score_hit;

    // Score for a hit: the bonus is judged on the streak length including this hit.
    always_comb begin
        w_streak_inc = (r_streak == 3'd7) ? 3'd7 : r_streak + 3'd1;
        w_score_sum  = {1'b0, r_score} +
                       (({1'b0, w_streak_inc} >= BONUS_AT) ? PTS_TWO : PTS_ONE);
        w_score_hit  = w_score_sum[SCORE_W] ? {SCORE_W{1'b1}} : w_score_sum[SCORE_W-1:0];
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_shots_left_nxt   = r_shots_left;
        w_score_nxt        = r_score;
        w_high_score_nxt   = r_high_score;
        w_streak_nxt       = r_streak;
        w_timeout_flag_nxt = r_timeout_flag;
        w_tmo_cnt_nxt      = r_tmo_cnt;
        w_launch           = 1'b0;
        w_resolve          = 1'b0;

        if (start_new_game) begin
            w_state_nxt        = S_READY;
            w_shots_left_nxt   = SHOTS_INIT;
            w_score_nxt        = '0;
            w_streak_nxt       = 3'd0;
            w_timeout_flag_nxt = 1'b0;
            w_tmo_cnt_nxt      = '0;
        end else begin
            case (r_state)
                S_READY: begin
                    if (shoot_req && (r_shots_left != 4'd0)) begin
                        w_state_nxt        = S_IN_FLIGHT;
                        w_shots_left_nxt   = r_shots_left - 4'd1;
                        w_tmo_cnt_nxt      = '0;
                        w_timeout_flag_nxt = 1'b0;
                        w_launch           = 1'b1;
                    end
                end
                S_IN_FLIGHT: begin
                    w_tmo_cnt_nxt = r_tmo_cnt + TMO_ONE;
                    if (result_valid) begin
                        w_resolve = 1'b1;
                        if (hit) begin
                            w_streak_nxt = w_streak_inc;
                            w_score_nxt  = w_score_hit;
                        end else begin
                            w_streak_nxt = 3'd0;
                        end
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_resolve          = 1'b1;
                        w_streak_nxt       = 3'd0;
                        w_timeout_flag_nxt = 1'b1;
                    end
                end
                default: ;
            endcase

            // The final shot's result is already folded into w_score_nxt here.
            if (w_resolve) begin
                if (r_shots_left == 4'd0) begin
                    w_state_nxt      = S_GAME_OVER;
                    w_high_score_nxt = (w_score_nxt > r_high_score) ? w_score_nxt : r_high_score;
                end else begin
                    w_state_nxt = S_READY;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_shots_left   <= 4'd0;
            r_score        <= '0;
            r_high_score   <= '0;
            r_streak       <= 3'd0;
            r_timeout_flag <= 1'b0;
            r_tmo_cnt      <= '0;
            r_shoot_out    <= 1'b0;
        end else begin
            // Pulse register is not held: a disabled cycle always clears it.
            r_shoot_out <= ena & w_launch;
            if (ena) begin
                r_state        <= w_state_nxt;
                r_shots_left   <= w_shots_left_nxt;
                r_score        <= w_score_nxt;
                r_high_score   <= w_high_score_nxt;
                r_streak       <= w_streak_nxt;
                r_timeout_flag <= w_timeout_flag_nxt;
                r_tmo_cnt      <= w_tmo_cnt_nxt;
            end
        end
    end

    assign shoot_out    = r_shoot_out;
    assign busy         = (r_state == S_IN_FLIGHT);
    assign game_over    = (r_state == S_GAME_OVER);
    assign shots_left   = r_shots_left;
    assign score        = r_score;
    assign high_score   = r_high_score;
    assign streak       = r_streak;
    assign timeout_flag = r_timeout_flag;
endmodule

// File: tb/tb_shot_scoreboard.sv
// Bench for shot_scoreboard: vector table, directed multi-cycle cases, then randomized run against a model.
module tb_shot_scoreboard;
    localparam int SW    = 6;
    localparam int SHOTS = 8;
    localparam int BONUS = 3;
    localparam int TMO   = 64;
    localparam int SMAX  = (1 << SW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ena = 1'b1;
    logic          start_new_game = 1'b0;
    logic          shoot_req = 1'b0;
    logic          result_valid = 1'b0;
    logic          hit = 1'b0;
    logic          shoot_out, busy, timeout_flag, game_over;
    logic [3:0]    shots_left;
    logic [SW-1:0] score, high_score;
    logic [2:0]    streak;

    shot_scoreboard #(
        .SHOTS_PER_GAME (SHOTS),
        .SCORE_W        (SW),
        .STREAK_BONUS_AT(BONUS),
        .TIMEOUT_CYC    (TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .ena           (ena),
        .start_new_game(start_new_game),
        .shoot_req     (shoot_req),
        .result_valid  (result_valid),
        .hit           (hit),
        .shoot_out     (shoot_out),
        .busy          (busy),
        .shots_left    (shots_left),
        .score         (score),
        .high_score    (high_score),
        .streak        (streak),
        .timeout_flag  (timeout_flag),
        .game_over     (game_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read at the same point.
    task automatic step(input logic s, input logic sh, input logic rv, input logic h, input logic en);
        start_new_game = s;
        shoot_req      = sh;
        result_valid   = rv;
        hit            = h;
        ena            = en;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 1);
    endtask

    task automatic do_reset();
        start_new_game = 0; shoot_req = 0; result_valid = 0; hit = 0; ena = 1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Reference model: game phase plus counters, advanced per enabled clock.
    int m_phase;   // 0 idle, 1 ready, 2 shot outstanding, 3 game finished
    int m_shots, m_score, m_hs, m_streak, m_tflag, m_age, m_so;

    task automatic m_reset();
        m_phase = 0; m_shots = 0; m_score = 0; m_hs = 0;
        m_streak = 0; m_tflag = 0; m_age = 0; m_so = 0;
    endtask

    task automatic m_resolve(input bit h);
        if (h) begin
            m_streak = (m_streak >= 7) ? 7 : m_streak + 1;
            m_score  = m_score + ((m_streak >= BONUS) ? 2 : 1);
            if (m_score > SMAX) m_score = SMAX;
        end else begin
            m_streak = 0;
        end
        if (m_shots == 0) begin
            m_phase = 3;
            if (m_score > m_hs) m_hs = m_score;
        end else begin
            m_phase = 1;
        end
    endtask

    task automatic m_step(input bit s, input bit sh, input bit rv, input bit h, input bit en);
        m_so = 0;
        if (en) begin
            if (s) begin
                m_phase = 1; m_shots = SHOTS; m_score = 0; m_streak = 0; m_tflag = 0;
            end else if (m_phase == 1 && sh && m_shots > 0) begin
                m_phase = 2; m_shots--; m_age = 0; m_tflag = 0; m_so = 1;
            end else if (m_phase == 2) begin
                if (rv) begin
                    m_resolve(h);
                end else if (m_age == TMO - 1) begin
                    m_tflag = 1;
                    m_resolve(0);
                end else begin
                    m_age++;
                end
            end
        end
    endtask

    typedef struct {
        logic s, sh, rv, h;
        int   shots, score, streak, hs;
        logic busy, so, go;
    } vec_t;

    vec_t tbl[22];

    initial begin
        tbl[0]  = '{0,1,1,1, 0, 0,0, 0, 0,0,0};
        tbl[1]  = '{1,0,0,0, 8, 0,0, 0, 0,0,0};
        tbl[2]  = '{0,1,0,0, 7, 0,0, 0, 1,1,0};
        tbl[3]  = '{0,1,0,0, 7, 0,0, 0, 1,0,0};
        tbl[4]  = '{0,0,1,1, 7, 1,1, 0, 0,0,0};
        tbl[5]  = '{0,1,0,0, 6, 1,1, 0, 1,1,0};
        tbl[6]  = '{0,0,1,1, 6, 2,2, 0, 0,0,0};
        tbl[7]  = '{0,1,0,0, 5, 2,2, 0, 1,1,0};
        tbl[8]  = '{0,0,1,1, 5, 4,3, 0, 0,0,0};
        tbl[9]  = '{0,1,0,0, 4, 4,3, 0, 1,1,0};
        tbl[10] = '{0,0,1,1, 4, 6,4, 0, 0,0,0};
        tbl[11] = '{0,1,0,0, 3, 6,4, 0, 1,1,0};
        tbl[12] = '{0,0,1,1, 3, 8,5, 0, 0,0,0};
        tbl[13] = '{0,1,0,0, 2, 8,5, 0, 1,1,0};
        tbl[14] = '{0,0,1,0, 2, 8,0, 0, 0,0,0};
        tbl[15] = '{0,0,1,1, 2, 8,0, 0, 0,0,0};
        tbl[16] = '{0,1,0,0, 1, 8,0, 0, 1,1,0};
        tbl[17] = '{0,0,1,1, 1, 9,1, 0, 0,0,0};
        tbl[18] = '{0,1,0,0, 0, 9,1, 0, 1,1,0};
        tbl[19] = '{0,0,1,1, 0,10,2,10, 0,0,1};
        tbl[20] = '{0,1,1,1, 0,10,2,10, 0,0,1};
        tbl[21] = '{1,0,0,0, 8, 0,0,10, 0,0,0};

        #2 reset = 1'b1;
        #8;
        chk("rst shots_left", int'(shots_left), 0);
        chk("rst score", int'(score), 0);
        chk("rst high_score", int'(high_score), 0);
        chk("rst streak", int'(streak), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst shoot_out", int'(shoot_out), 0);
        chk("rst game_over", int'(game_over), 0);
        chk("rst timeout_flag", int'(timeout_flag), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].s, tbl[i].sh, tbl[i].rv, tbl[i].h, 1'b1);
            chk($sformatf("row%0d shots_left", i), int'(shots_left), tbl[i].shots);
            chk($sformatf("row%0d score", i), int'(score), tbl[i].score);
            chk($sformatf("row%0d streak", i), int'(streak), tbl[i].streak);
            chk($sformatf("row%0d high_score", i), int'(high_score), tbl[i].hs);
            chk($sformatf("row%0d busy", i), int'(busy), int'(tbl[i].busy));
            chk($sformatf("row%0d shoot_out", i), int'(shoot_out), int'(tbl[i].so));
            chk($sformatf("row%0d game_over", i), int'(game_over), int'(tbl[i].go));
        end

        // Unanswered shot: 64 cycles in flight, then forced miss.
        step(0, 1, 0, 0, 1);
        idle(TMO - 1);
        chk("tmo still busy", int'(busy), 1);
        idle(1);
        chk("tmo busy", int'(busy), 0);
        chk("tmo flag", int'(timeout_flag), 1);
        chk("tmo score", int'(score), 0);
        chk("tmo shots_left", int'(shots_left), 7);

        // Result on the last in-flight cycle still counts.
        step(0, 1, 0, 0, 1);
        chk("launch clears flag", int'(timeout_flag), 0);
        idle(TMO - 1);
        step(0, 0, 1, 1, 1);
        chk("late hit busy", int'(busy), 0);
        chk("late hit score", int'(score), 1);
        chk("late hit streak", int'(streak), 1);
        chk("late hit flag", int'(timeout_flag), 0);

        // Disabled cycles freeze the timeout count and ignore inputs.
        step(0, 1, 0, 0, 1);
        idle(5);
        for (int k = 0; k < 10; k++) step(0, 1, 1, 1, 0);
        chk("ena0 busy", int'(busy), 1);
        chk("ena0 shots_left", int'(shots_left), 5);
        chk("ena0 score", int'(score), 1);
        chk("ena0 shoot_out", int'(shoot_out), 0);
        idle(TMO - 6);
        chk("ena0 still busy", int'(busy), 1);
        idle(1);
        chk("ena0 tmo busy", int'(busy), 0);
        chk("ena0 tmo flag", int'(timeout_flag), 1);

        // Restart abandons the outstanding shot and its coincident result.
        step(0, 1, 0, 0, 1);
        step(1, 0, 1, 1, 1);
        chk("restart shots_left", int'(shots_left), 8);
        chk("restart score", int'(score), 0);
        chk("restart busy", int'(busy), 0);
        step(0, 0, 1, 1, 1);
        chk("stray result score", int'(score), 0);

        // Asynchronous reset while a shot is outstanding.
        step(0, 1, 0, 0, 1);
        #2 reset = 1'b1;
        #1;
        chk("async rst busy", int'(busy), 0);
        chk("async rst shots_left", int'(shots_left), 0);
        chk("async rst high_score", int'(high_score), 0);
        chk("async rst game_over", int'(game_over), 0);
        @(negedge clk);
        reset = 1'b0;

        // Full game with three scattered hits, then a weaker game.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 1);
            step(0, 0, 1, (i % 3) == 0, 1);
        end
        chk("game1 over", int'(game_over), 1);
        chk("game1 score", int'(score), 3);
        chk("game1 high_score", int'(high_score), 3);
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 1);
            step(0, 0, 1, i == 0, 1);
        end
        chk("game2 over", int'(game_over), 1);
        chk("game2 score", int'(score), 1);
        chk("game2 high_score", int'(high_score), 3);

        // Eight straight hits: streak saturates at 7.
        step(1, 0, 0, 0, 1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 0, 0, 1);
            step(0, 0, 1, 1, 1);
        end
        chk("game3 streak", int'(streak), 7);
        chk("game3 score", int'(score), 14);
        chk("game3 high_score", int'(high_score), 14);

        do_reset();
        m_reset();
        for (int c = 0; c < 4000; c++) begin
            bit s, sh, rv, h, en;
            int rv_pct;
            rv_pct = ((c / 400) % 2 == 1) ? 1 : 25;
            s  = ($urandom_range(99) < 2);
            sh = ($urandom_range(99) < 35);
            rv = ($urandom_range(99) < rv_pct);
            h  = ($urandom_range(99) < 75);
            en = ($urandom_range(99) < 90);
            m_step(s, sh, rv, h, en);
            step(s, sh, rv, h, en);
            chk($sformatf("rnd%0d shoot_out", c), int'(shoot_out), m_so);
            chk($sformatf("rnd%0d busy", c), int'(busy), int'(m_phase == 2));
            chk($sformatf("rnd%0d game_over", c), int'(game_over), int'(m_phase == 3));
            chk($sformatf("rnd%0d shots_left", c), int'(shots_left), m_shots);
            chk($sformatf("rnd%0d score", c), int'(score), m_score);
            chk($sformatf("rnd%0d high_score", c), int'(high_score), m_hs);
            chk($sformatf("rnd%0d streak", c), int'(streak), m_streak);
            chk($sformatf("rnd%0d timeout_flag", c), int'(timeout_flag), m_tflag);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
